// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: TX holding FIFO with a first-word fall-through head byte and its parity bit.
// Optional sticky overflow flag is built when `UART_TX_FIFO_OVERFLOW_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int PTR_W = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              odd_parity_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_parity_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [PTR_W-1:0]  count_o,
    output logic              overflow_o,
    input  logic              ovf_clear_i
);

    function automatic logic parity_bit(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    // The pointer MSB is a wrap bit: equal low bits mean empty or full depending on it.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign wr_ready_o = !full;
    assign rd_valid_o = !empty;
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = rd_valid_o && rd_ready_i;

    assign count_o     = wr_ptr - rd_ptr;
    assign rd_data_o   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign rd_parity_o = parity_bit(rd_data_o, odd_parity_i);

    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            mem[wr_ptr[AW-1:0]] <= wr_data_i;
        end
    end

    // Flush behaves like reset for the pointers but leaves the overflow flag alone.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic ovf_q;

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (wr_valid_i && !wr_ready_o) begin
            ovf_q <= 1'b1;
        end else if (ovf_clear_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow_o = ovf_q;
`else
    logic unused_ovf_clear;

    assign unused_ovf_clear = ovf_clear_i;
    assign overflow_o       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a queue scoreboard checked by a negedge monitor.
// Overflow expectations follow `UART_TX_FIFO_OVERFLOW_EN, matching the DUT build.
module tb_uart_tx_fifo;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(DEPTH) + 1;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              flush_i = 1'b0;
    logic              odd_parity_i = 1'b0;
    logic [DATA_W-1:0] wr_data_i = '0;
    logic              wr_valid_i = 1'b0;
    logic              wr_ready_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_parity_o;
    logic              rd_valid_o;
    logic              rd_ready_i = 1'b0;
    logic [PTR_W-1:0]  count_o;
    logic              overflow_o;
    logic              ovf_clear_i = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .odd_parity_i (odd_parity_i),
        .wr_data_i    (wr_data_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .rd_data_o    (rd_data_o),
        .rd_parity_o  (rd_parity_o),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .ovf_clear_i  (ovf_clear_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;
    logic [DATA_W-1:0] exp_q [$];
    bit ovf_m = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: check outputs against the model, then advance the model by what the next edge does.
    always @(negedge clk) begin
        if (armed) begin
            bit was_full;
            bit was_empty;
            was_full  = (exp_q.size() == DEPTH);
            was_empty = (exp_q.size() == 0);
            chk("count", int'(count_o), exp_q.size());
            chk("rd_valid", int'(rd_valid_o), int'(!was_empty));
            chk("wr_ready", int'(wr_ready_o), int'(!was_full));
            chk("overflow", int'(overflow_o), int'(ovf_m));
            if (was_empty) begin
                chk("rd_data_empty", int'(rd_data_o), 0);
                chk("parity_empty", int'(rd_parity_o), int'(odd_parity_i));
            end else begin
                chk("parity_head", int'(rd_parity_o), int'((^exp_q[0]) ^ odd_parity_i));
            end
            if (rst_i || flush_i) begin
                exp_q.delete();
            end else begin
                if (rd_ready_i && !was_empty) begin
                    chk("pop_data", int'(rd_data_o), int'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                if (wr_valid_i && !was_full) exp_q.push_back(wr_data_i);
            end
            if (rst_i) ovf_m = 1'b0;
            else if (OVF_EN && wr_valid_i && was_full) ovf_m = 1'b1;
            else if (ovf_clear_i) ovf_m = 1'b0;
        end
    end

    task automatic push_byte(input logic [DATA_W-1:0] d);
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        cyc();
        wr_valid_i = 1'b0;
    endtask

    task automatic drain_frames();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            rd_ready_i = 1'b1;
            cyc();
            rd_ready_i = 1'b0;
            repeat (3) cyc();
            guard++;
        end
        chk("drain_timeout", guard < 200 ? 1 : 0, 1);
    endtask

    initial begin
        repeat (2) cyc();
        armed = 1'b1;
        rst_i = 1'b0;
        chk("rst_count", int'(count_o), 0);
        chk("rst_rd_valid", int'(rd_valid_o), 0);
        chk("rst_wr_ready", int'(wr_ready_o), 1);
        chk("rst_overflow", int'(overflow_o), 0);

        // Single byte: FWFT head and parity in both modes.
        push_byte(8'hA5);
        chk("a5_valid", int'(rd_valid_o), 1);
        chk("a5_data", int'(rd_data_o), 'hA5);
        chk("a5_count", int'(count_o), 1);
        chk("a5_par_even", int'(rd_parity_o), 0);
        odd_parity_i = 1'b1;
        #1;
        chk("a5_par_odd", int'(rd_parity_o), 1);
        rd_ready_i = 1'b1;
        cyc();
        rd_ready_i = 1'b0;
        chk("a5_popped", int'(count_o), 0);
        odd_parity_i = 1'b0;

        // Fill, overflow attempt, clear, drain in order.
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        chk("full_count", int'(count_o), 16);
        chk("full_wr_ready", int'(wr_ready_o), 0);
        push_byte(8'hEE);
        chk("ovf_set", int'(overflow_o), int'(OVF_EN));
        chk("drop_count", int'(count_o), 16);
        ovf_clear_i = 1'b1;
        cyc();
        ovf_clear_i = 1'b0;
        chk("ovf_clr", int'(overflow_o), 0);
        drain_frames();
        chk("drained_valid", int'(rd_valid_o), 0);
        chk("drained_data", int'(rd_data_o), 0);

        // Full with simultaneous push and pop: only the pop happens.
        for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h77;
        rd_ready_i = 1'b1;
        cyc();
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        chk("fullrw_count", int'(count_o), 15);
        chk("fullrw_head", int'(rd_data_o), 'h11);
        ovf_clear_i = 1'b1;
        cyc();
        ovf_clear_i = 1'b0;
        drain_frames();

        // Steady push+pop at count 5 across several pointer wraps.
        for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
        wr_valid_i = 1'b1;
        rd_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data_i = 8'h40 + 8'(i);
            cyc();
            chk("steady_count", int'(count_o), 5);
        end
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        chk("steady_head", int'(rd_data_o), 'h40 + 35);
        drain_frames();

        // Flush with a concurrent push; overflow survives the flush.
        for (int i = 0; i < DEPTH; i++) push_byte(8'h50 + 8'(i));
        push_byte(8'hEE);
        wr_valid_i = 1'b0;
        cyc();
        for (int i = 0; i < 9; i++) begin
            rd_ready_i = 1'b1;
            cyc();
        end
        rd_ready_i = 1'b0;
        chk("pre_flush_count", int'(count_o), 7);
        flush_i    = 1'b1;
        wr_valid_i = 1'b1;
        wr_data_i  = 8'h99;
        cyc();
        flush_i    = 1'b0;
        wr_valid_i = 1'b0;
        chk("flush_count", int'(count_o), 0);
        chk("flush_valid", int'(rd_valid_o), 0);
        chk("flush_ovf_kept", int'(overflow_o), int'(OVF_EN));

        // Reset mid-stream discards data and clears overflow.
        for (int i = 0; i < 7; i++) push_byte(8'h60 + 8'(i));
        rst_i = 1'b1;
        wr_valid_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        wr_valid_i = 1'b0;
        chk("rst2_count", int'(count_o), 0);
        chk("rst2_valid", int'(rd_valid_o), 0);
        chk("rst2_ovf", int'(overflow_o), 0);
        chk("rst2_wr_ready", int'(wr_ready_o), 1);
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
